// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller: edge-latched sources, I/O mask/status, vector on INTA.
// Latency: irq edge -> nINT low in 4 clk; I/O writes act 2 clk after the strobe is first sampled.
// Flow control: none; the CPU paces everything through its bus strobes, and the controller never stalls the CPU.
//
// Ports: clk/reset (async, active-high); irq[NUM_SRC] rising-edge requests;
//   nM1/nIORQ/nRD/nWR/A/D_in from the Z80 bus; nINT to the CPU; D_out/D_oe drive the data bus
//   for status reads (IO_BASE = pending, IO_BASE+1 = mask) and for the IM2 vector during acknowledge.
// Build option: define Z80_INT_CTRL_ROTATE_EN for round-robin priority (default: lowest index wins).
module z80_int_ctrl #(
  parameter int         NUM_SRC     = 4,
  parameter logic [7:0] VECTOR_BASE = 8'h80,
  parameter logic [7:0] IO_BASE     = 8'h10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               nM1,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  input  logic [7:0]         A,
  input  logic [7:0]         D_in,
  output logic               nINT,
  output logic [7:0]         D_out,
  output logic               D_oe
);

  localparam int         IW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [7:0] MASK_ADDR = IO_BASE;
  localparam logic [7:0] EOI_ADDR  = IO_BASE + 8'd1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irqMeta, irqSync, irqPrev;
  logic [NUM_SRC-1:0] pending, mask, enabled, irqRise;
  logic [IW-1:0]      winner, pick;
  logic               inService;
  logic               wrStb, wrStbPrev, wrFire;
  logic [7:0]         wrAddr, wrData;
  logic               intAck, ioRd, ioWr, maskWr, eoiWr, goAck;
  logic [7:0]         vector;

  assign intAck  = !nM1 && !nIORQ;
  assign ioRd    = !nIORQ && !nRD && nM1;
  assign ioWr    = !nIORQ && !nWR && nM1;
  assign irqRise = irqSync & ~irqPrev;
  assign enabled = pending & mask;
  assign wrFire  = wrStb && !wrStbPrev;
  assign maskWr  = wrFire && (wrAddr == MASK_ADDR);
  assign eoiWr   = wrFire && (wrAddr == EOI_ADDR);
  // Acknowledge only counts while the latched winner is still enabled.
  assign goAck   = (state == REQ) && mask[winner] && intAck;
  assign vector  = VECTOR_BASE + (8'(winner) << 1);

  // Request synchronizer and edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqMeta <= '0;
      irqSync <= '0;
      irqPrev <= '0;
    end else begin
      irqMeta <= irq;
      irqSync <= irqMeta;
      irqPrev <= irqSync;
    end
  end

  // Write strobe is registered with its address/data so each bus cycle acts exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrStb     <= 1'b0;
      wrStbPrev <= 1'b0;
      wrAddr    <= 8'h00;
      wrData    <= 8'h00;
    end else begin
      wrStb     <= ioWr;
      wrStbPrev <= wrStb;
      wrAddr    <= A;
      wrData    <= D_in;
    end
  end

  // Clear-then-set ordering keeps an edge that lands on the acknowledge cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~(goAck ? (NUM_SRC'(1) << winner) : '0)) | irqRise;
      if (maskWr) mask <= NUM_SRC'(wrData);
    end
  end

`ifdef Z80_INT_CTRL_ROTATE_EN
  // Resets to the top index so the first search after reset starts at source 0.
  logic [IW-1:0] lastGrant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      lastGrant <= IW'(NUM_SRC - 1);
    else if (goAck) lastGrant <= winner;
  end

  always_comb begin
    int  sum;
    logic found;
    pick  = '0;
    found = 1'b0;
    sum   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = int'(lastGrant) + 1 + i;
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      if (!found && enabled[IW'(sum)]) begin
        pick  = IW'(sum);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && enabled[i]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      nINT      <= 1'b1;
      winner    <= '0;
      inService <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|enabled) begin
            winner <= pick;
            state  <= REQ;
            nINT   <= 1'b0;
          end
        end
        REQ: begin
          // Masking the winner withdraws the request; its pending bit stays.
          if (!mask[winner]) begin
            state <= IDLE;
            nINT  <= 1'b1;
          end else if (intAck) begin
            state     <= ACK;
            nINT      <= 1'b1;
            inService <= 1'b1;
          end
        end
        ACK: begin
          if (!intAck) state <= SERVICE;
        end
        SERVICE: begin
          if (eoiWr) begin
            state     <= IDLE;
            inService <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drive is combinational on the live strobes and forced off during reset.
  always_comb begin
    D_out = 8'h00;
    D_oe  = 1'b0;
    if (!reset) begin
      if (state == ACK && intAck && inService) begin
        D_out = vector;
        D_oe  = 1'b1;
      end else if (ioRd && A == MASK_ADDR) begin
        D_out = 8'(pending);
        D_oe  = 1'b1;
      end else if (ioRd && A == EOI_ADDR) begin
        D_out = 8'(mask);
        D_oe  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl: directed scenarios followed by randomized
// mask/irq/acknowledge/EOI traffic checked against an event-level model.
module tb_z80_int_ctrl;

  localparam logic [7:0] MASK_PORT = 8'h10;
  localparam logic [7:0] EOI_PORT  = 8'h11;
`ifdef Z80_INT_CTRL_ROTATE_EN
  localparam logic [7:0] PAIR_FIRST  = 8'h86;
  localparam logic [7:0] PAIR_SECOND = 8'h82;
`else
  localparam logic [7:0] PAIR_FIRST  = 8'h82;
  localparam logic [7:0] PAIR_SECOND = 8'h86;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       nM1, nIORQ, nRD, nWR;
  logic [7:0] A, D_in;
  logic       nINT, D_oe;
  logic [7:0] D_out;
  logic       nInt2, dOe2;
  logic [7:0] dOut2;

  int checks = 0;
  int errors = 0;

  // Reference state: pending/mask bits, whether a request is outstanding, the
  // granted source, whether a service routine is running, and the last grant.
  logic [3:0] pendM, maskM;
  logic       reqOn, serving;
  int         win, lastG;

  logic [7:0] ackVec, ackVec2, rd;
  logic       ackOe, ackNint, rdOe;
  int         n;

  z80_int_ctrl #(.NUM_SRC(4), .VECTOR_BASE(8'h80), .IO_BASE(8'h10)) dut (
    .clk(clk), .reset(reset), .irq(irq), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .A(A), .D_in(D_in), .nINT(nINT), .D_out(D_out), .D_oe(D_oe));

  // Second instance with a base near 0xFF to exercise vector wraparound.
  z80_int_ctrl #(.NUM_SRC(4), .VECTOR_BASE(8'hFE), .IO_BASE(8'h10)) dutWrap (
    .clk(clk), .reset(reset), .irq(irq), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .A(A), .D_in(D_in), .nINT(nInt2), .D_out(dOut2), .D_oe(dOe2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
    A = addr; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
    tick(); tick();
    nIORQ = 1'b1; nWR = 1'b1;
    tick();
  endtask

  task automatic ioRead(input logic [7:0] addr, output logic [7:0] d, output logic oe);
    A = addr; nIORQ = 1'b0; nRD = 1'b0;
    #1;
    d = D_out; oe = D_oe;
    nIORQ = 1'b1; nRD = 1'b1;
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    irq = irq | m;
    tick(); tick();
    irq = irq & ~m;
    tick();
  endtask

  task automatic waitInt(output int cnt);
    cnt = 0;
    while (nINT !== 1'b0 && cnt < 8) begin
      tick();
      cnt++;
    end
  endtask

  task automatic intAck();
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    ackVec = D_out; ackOe = D_oe; ackNint = nINT; ackVec2 = dOut2;
    nM1 = 1'b1; nIORQ = 1'b1;
    tick();
  endtask

  function automatic int pickWin(input logic [3:0] en, input int last);
    logic [1:0] j;
    j = 2'd0;
`ifdef Z80_INT_CTRL_ROTATE_EN
    for (int k = 1; k <= 4; k++) begin
      j = 2'(last + k);
      if (en[j]) return int'(j);
    end
`else
    for (int k = 0; k < 4; k++) begin
      j = 2'(k);
      if (en[j]) return k;
    end
`endif
    return 0;
  endfunction

  // Outstanding requests are withdrawn when masked; a new grant is chosen only
  // when nothing is outstanding and no service routine is running.
  task automatic modelEval();
    if (reqOn && !maskM[win]) reqOn = 1'b0;
    if (!reqOn && !serving && (pendM & maskM) != 4'h0) begin
      win   = pickWin(pendM & maskM, lastG);
      reqOn = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; irq = 4'h0;
    nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    A = 8'h00; D_in = 8'h00;
    #1;
    chk("reset_nint", nINT, 1);
    chk("reset_doe", D_oe, 0);
    chk("reset_dout", D_out, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();
    ioRead(MASK_PORT, rd, rdOe);
    chk("reset_pending", rd, 8'h00);
    chk("read_oe", rdOe, 1);
    ioRead(EOI_PORT, rd, rdOe);
    chk("reset_mask", rd, 8'h00);
    chk("idle_doe", D_oe, 0);

    // Single source: latency, vector, pending clear
    ioWrite(MASK_PORT, 8'h0F);
    irq = 4'b0100;
    waitInt(n);
    irq = 4'h0;
    chk("irq2_nint", nINT, 0);
    chk("irq2_latency_le4", (n <= 4), 1);
    intAck();
    chk("irq2_vector", ackVec, 8'h84);
    chk("irq2_vec_oe", ackOe, 1);
    chk("irq2_nint_in_ack", ackNint, 1);
    chk("irq2_vector_wrap", ackVec2, 8'h02);
    ioRead(MASK_PORT, rd, rdOe);
    chk("irq2_pending_clr", rd, 8'h00);
    ioWrite(EOI_PORT, 8'h00);

    // Make source 1 the last grant, then raise 1 and 3 together
    pulse(4'b0010);
    waitInt(n);
    intAck();
    chk("src1_vector", ackVec, 8'h82);
    ioWrite(EOI_PORT, 8'h00);
    pulse(4'b1010);
    waitInt(n);
    intAck();
    chk("pair_first", ackVec, PAIR_FIRST);
    ioWrite(EOI_PORT, 8'h00);
    waitInt(n);
    intAck();
    chk("pair_second", ackVec, PAIR_SECOND);
    ioWrite(EOI_PORT, 8'h00);
    tick(); tick();
    chk("pair_done_nint", nINT, 1);

    // Masked source stays pending; enabling it raises the interrupt
    ioWrite(MASK_PORT, 8'h00);
    pulse(4'b0001);
    tick(); tick(); tick();
    chk("masked_nint", nINT, 1);
    ioRead(MASK_PORT, rd, rdOe);
    chk("masked_pending", rd, 8'h01);
    ioWrite(MASK_PORT, 8'h01);
    waitInt(n);
    chk("unmask_nint", nINT, 0);
    ioWrite(EOI_PORT, 8'h00);
    chk("eoi_in_req_ignored", nINT, 0);

    // Mask withdrawal in REQ, then new edge during SERVICE
    ioWrite(MASK_PORT, 8'h00);
    chk("withdraw_nint", nINT, 1);
    ioRead(MASK_PORT, rd, rdOe);
    chk("withdraw_pending_kept", rd, 8'h01);
    ioWrite(MASK_PORT, 8'h01);
    waitInt(n);
    intAck();
    chk("src0_vector", ackVec, 8'h80);
    pulse(4'b0001);
    tick(); tick(); tick();
    chk("service_nint_held", nINT, 1);
    ioRead(MASK_PORT, rd, rdOe);
    chk("service_pending", rd, 8'h01);
    ioWrite(EOI_PORT, 8'hFF);
    waitInt(n);
    chk("after_eoi_nint", nINT, 0);

    // Reset in the middle of an acknowledge
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    chk("ack_doe_before_rst", D_oe, 1);
    reset = 1'b1;
    #1;
    chk("rst_ack_nint", nINT, 1);
    chk("rst_ack_doe", D_oe, 0);
    nM1 = 1'b1; nIORQ = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ioRead(MASK_PORT, rd, rdOe);
    chk("rst_pending", rd, 8'h00);
    ioRead(EOI_PORT, rd, rdOe);
    chk("rst_mask", rd, 8'h00);
    chk("rst_nint_after", nINT, 1);

    // Randomized traffic against the model
    pendM = 4'h0; maskM = 4'h0; reqOn = 1'b0; serving = 1'b0; win = 0; lastG = 3;
    for (int it = 0; it < 80; it++) begin
      logic [3:0] m;
      case ($urandom_range(0, 3))
        0: begin
          m = 4'($urandom_range(0, 15));
          ioWrite(MASK_PORT, {4'h0, m});
          maskM = m;
          modelEval();
        end
        1: begin
          m = 4'($urandom_range(1, 15));
          pulse(m);
          pendM = pendM | m;
          modelEval();
        end
        2: begin
          if (reqOn) begin
            intAck();
            chk("rnd_vector", ackVec, 8'(8'h80 + 2 * win));
            chk("rnd_vector_wrap", ackVec2, 8'(8'hFE + 2 * win));
            chk("rnd_vec_oe", ackOe, 1);
            pendM[win] = 1'b0;
            reqOn = 1'b0;
            serving = 1'b1;
            lastG = win;
          end else begin
            intAck();
            chk("rnd_stray_ack_oe", ackOe, 0);
          end
          modelEval();
        end
        default: begin
          ioWrite(EOI_PORT, 8'($urandom_range(0, 255)));
          serving = 1'b0;
          modelEval();
        end
      endcase
      tick(); tick(); tick(); tick();
      chk("rnd_nint", nINT, {31'd0, !reqOn});
      ioRead(MASK_PORT, rd, rdOe);
      chk("rnd_pending", rd, {4'h0, pendM});
      ioRead(EOI_PORT, rd, rdOe);
      chk("rnd_mask", rd, {4'h0, maskM});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_int_ctrl.md
Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_SRC, default 4, number of interrupt sources (1..8); VECTOR_BASE, default 8'h80, IM2 vector of source 0; IO_BASE, default 8'h10, base I/O port (low byte of A).
REQ-002 clk  input  1  block clock; all CPU strobes are sampled in this domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 irq  input  NUM_SRC  interrupt requests; rising-edge sensitive.
REQ-005 nM1, nIORQ, nRD, nWR  input  1 each  Z80 bus strobes, active-low.
REQ-006 A  input  8  I/O address, low byte.
REQ-007 D_in  input  8  CPU write data.
REQ-008 nINT  output  1  maskable interrupt to CPU, active-low.
REQ-009 D_out  output  8  read data or vector.
REQ-010 D_oe  output  1  high when D_out is to drive the data bus.

Function
REQ-011 irq SHALL pass through a 2-flop synchronizer; a synchronized 0->1 edge SHALL set pending[i], one cycle after the synchronizer output.
REQ-012 I/O write at IO_BASE (nIORQ=0, nWR=0, nM1=1) SHALL load mask[NUM_SRC-1:0] from D_in; 1 = enabled.
REQ-013 I/O write at IO_BASE+1 SHALL be EOI: clear in_service, return FSM to IDLE; D_in is ignored.
REQ-014 I/O read at IO_BASE SHALL return {pending padded to 8 bits}; IO_BASE+1 SHALL return {mask padded}; D_oe=1 only while nIORQ=0, nRD=0, nM1=1 and the address matches.
REQ-015 Writes and EOI SHALL act once per strobe, on the first clk where the registered strobe is asserted (edge detect).
REQ-016 FSM states: IDLE, REQ, ACK, SERVICE.
REQ-017 IDLE -> REQ when (pending & mask) != 0; the winner index SHALL be latched on that transition; nINT=0 in REQ.
REQ-018 REQ -> ACK on the first clk with nM1=0 and nIORQ=0 (interrupt acknowledge); on entry, pending[winner] SHALL clear and nINT SHALL go 1.
REQ-019 In ACK, D_out SHALL equal VECTOR_BASE + 2*winner and D_oe=1 while nM1=0 and nIORQ=0; ACK -> SERVICE when the strobe is released.
REQ-020 SERVICE SHALL hold nINT=1 regardless of new pending bits until EOI; EOI -> IDLE.
REQ-021 In REQ, if the mask clears the winner's bit before the acknowledge, the FSM SHALL return to IDLE and release nINT the next cycle; pending is retained.
REQ-022 An edge on a source already pending SHALL be absorbed: no count, no second interrupt.
REQ-023 An edge arriving in the same cycle its pending bit clears (REQ->ACK) SHALL leave pending set.
REQ-024 Vector arithmetic SHALL be 8-bit and wrap modulo 256.
REQ-025 An EOI outside SERVICE SHALL be ignored.

Reset
REQ-026 Reset SHALL set: FSM=IDLE, pending=0, mask=0, in_service=0, synchronizers=0, nINT=1, D_oe=0, D_out=8'h00.
REQ-027 Reset during REQ, ACK or SERVICE SHALL abort immediately; nINT=1 and D_oe=0 asynchronously.

Configuration
REQ-028 Macro Z80_INT_CTRL_ROTATE_EN defined: round-robin priority; the search SHALL start at the index after the last granted source.
REQ-029 Macro undefined: fixed priority, lowest index wins; no rotation register is present.

Verification
REQ-030 Reset, write mask 8'h0F, pulse irq[2] -> nINT=0 within 4 clk; acknowledge -> D_out=8'h84, D_oe=1; pending[2]=0.
REQ-031 irq[1] and irq[3] edge in the same cycle, fixed priority -> vector 8'h82; after EOI, second interrupt -> vector 8'h86.
REQ-032 Same stimulus with Z80_INT_CTRL_ROTATE_EN, last grant=1 -> first vector 8'h86, then 8'h82.
REQ-033 Mask=0, pulse irq[0] -> nINT stays 1, pending read = 8'h01; write mask 8'h01 -> nINT=0.
REQ-034 In REQ, write mask 8'h00 -> nINT=1 next cycle; in SERVICE, irq[0] edge -> nINT stays 1 until EOI, then asserts.
REQ-035 Assert reset during ACK -> nINT=1, D_oe=0 same cycle; all registers read 0 afterwards.
